// File: rtl/tile_sched_pkg.sv
// Shared types and defaults for the tile scheduler.
// Holds the FSM state encoding, tiling defaults and the config-range check.
package tile_sched_pkg;

  localparam int MAX_TILES  = 32;
  localparam int TILE_WORDS = 128;
  localparam int RES_STRIDE = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_OVL,
    S_WB,
    S_DONE
  } state_e;

  function automatic logic cfg_ok(
    input logic [5:0] n,
    input int         max
  );
    return (n != 6'd0) && (int'(n) <= max);
  endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Row-major tile index walker: column first, wraps into the next row.
// Ports: clr_i zeroes, adv_i steps; nrow_i/ncol_i bounds; row_o/col_o, last_o.
module tile_index_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic [5:0] nrow_i,
  input  logic [5:0] ncol_i,
  output logic [4:0] row_o,
  output logic [4:0] col_o,
  output logic       last_o
);

  logic [4:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic       col_wrap;

  assign col_wrap = ({1'b0, col_q} == ncol_i - 6'd1);
  assign last_o   = col_wrap && ({1'b0, row_q} == nrow_i - 6'd1);
  assign row_o    = row_q;
  assign col_o    = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Sequences load/compute/write-back per tile, overlapping write-back with next load.
// Ports: start+cfg in; load/comp/wb req/done handshakes; busy, done, cfg_err, tiles_done.
module tile_scheduler #(
  parameter int MAX_TILES  = tile_sched_pkg::MAX_TILES,
  parameter int TILE_WORDS = tile_sched_pkg::TILE_WORDS,
  parameter int RES_STRIDE = tile_sched_pkg::RES_STRIDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cfg_row_tiles,
  input  logic [5:0]  cfg_col_tiles,
  output logic        load_req,
  output logic [4:0]  load_row,
  output logic [4:0]  load_col,
  input  logic        load_done,
  output logic        comp_req,
  input  logic        comp_done,
  output logic        wb_req,
  output logic [16:0] wb_addr_base,
  input  logic        wb_done,
  output logic [10:0] tiles_done,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  import tile_sched_pkg::state_e;
  import tile_sched_pkg::S_IDLE;
  import tile_sched_pkg::S_LOAD;
  import tile_sched_pkg::S_COMP;
  import tile_sched_pkg::S_OVL;
  import tile_sched_pkg::S_WB;
  import tile_sched_pkg::S_DONE;
  import tile_sched_pkg::cfg_ok;

  state_e      state_q, state_d;
  logic [5:0]  nrow_q, nrow_d;
  logic [5:0]  ncol_q, ncol_d;
  logic        ld_req_q, ld_req_d;
  logic        cp_req_q, cp_req_d;
  logic        wb_req_q, wb_req_d;
  logic        ld_seen_q, ld_seen_d;
  logic        wb_seen_q, wb_seen_d;
  logic [10:0] tiles_q, tiles_d;
  logic [16:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic        cnt_clr, cnt_adv;
  logic [4:0]  idx_row, idx_col;
  logic        idx_last;
  logic        ld_acc, cp_acc, wb_acc;
  logic        cfg_good;

  tile_index_counter u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .adv_i  (cnt_adv),
    .nrow_i (nrow_q),
    .ncol_i (ncol_q),
    .row_o  (idx_row),
    .col_o  (idx_col),
    .last_o (idx_last)
  );

  // A done pulse only counts while its request is up.
  assign ld_acc = load_done && ld_req_q;
  assign cp_acc = comp_done && cp_req_q;
  assign wb_acc = wb_done && wb_req_q;

  assign cfg_good = cfg_ok(cfg_row_tiles, MAX_TILES)
                 && cfg_ok(cfg_col_tiles, MAX_TILES);

  always_comb begin
    state_d   = state_q;
    nrow_d    = nrow_q;
    ncol_d    = ncol_q;
    ld_req_d  = ld_req_q;
    cp_req_d  = cp_req_q;
    wb_req_d  = wb_req_q;
    ld_seen_d = ld_seen_q;
    wb_seen_d = wb_seen_q;
    tiles_d   = tiles_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (cfg_good) begin
            state_d  = S_LOAD;
            nrow_d   = cfg_row_tiles;
            ncol_d   = cfg_col_tiles;
            cnt_clr  = 1'b1;
            ld_req_d = 1'b1;
            tiles_d  = '0;
            addr_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (ld_acc) begin
          ld_req_d = 1'b0;
          cp_req_d = 1'b1;
          state_d  = S_COMP;
        end
      end
      S_COMP: begin
        if (cp_acc) begin
          cp_req_d = 1'b0;
          wb_req_d = 1'b1;
          addr_d   = 17'(TILE_WORDS)
                   * (17'(idx_row) * 17'(RES_STRIDE) + 17'(idx_col));
          if (idx_last) begin
            state_d = S_WB;
          end else begin
            state_d   = S_OVL;
            cnt_adv   = 1'b1;
            ld_req_d  = 1'b1;
            ld_seen_d = 1'b0;
            wb_seen_d = 1'b0;
          end
        end
      end
      S_OVL: begin
        if (ld_acc) begin
          ld_req_d  = 1'b0;
          ld_seen_d = 1'b1;
        end
        if (wb_acc) begin
          wb_req_d  = 1'b0;
          wb_seen_d = 1'b1;
          tiles_d   = tiles_q + 11'd1;
        end
        // Compute waits for both the fresh operands and the drained result.
        if ((ld_seen_q || ld_acc) && (wb_seen_q || wb_acc)) begin
          state_d  = S_COMP;
          cp_req_d = 1'b1;
        end
      end
      S_WB: begin
        if (wb_acc) begin
          wb_req_d = 1'b0;
          tiles_d  = tiles_q + 11'd1;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nrow_q    <= '0;
      ncol_q    <= '0;
      ld_req_q  <= 1'b0;
      cp_req_q  <= 1'b0;
      wb_req_q  <= 1'b0;
      ld_seen_q <= 1'b0;
      wb_seen_q <= 1'b0;
      tiles_q   <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nrow_q    <= nrow_d;
      ncol_q    <= ncol_d;
      ld_req_q  <= ld_req_d;
      cp_req_q  <= cp_req_d;
      wb_req_q  <= wb_req_d;
      ld_seen_q <= ld_seen_d;
      wb_seen_q <= wb_seen_d;
      tiles_q   <= tiles_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  assign load_req     = ld_req_q;
  assign load_row     = idx_row;
  assign load_col     = idx_col;
  assign comp_req     = cp_req_q;
  assign wb_req       = wb_req_q;
  assign wb_addr_base = addr_q;
  assign tiles_done   = tiles_q;
  assign cfg_err      = err_q;
  assign done         = (state_q == S_DONE);
  assign busy         = (state_q == S_LOAD) || (state_q == S_COMP)
                     || (state_q == S_OVL)  || (state_q == S_WB);

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: reset, 1x1, 2x3, overlap ordering,
// config errors and mid-run reset followed by a full 32x32 run.
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  cfg_row_tiles = '0;
  logic [5:0]  cfg_col_tiles = '0;
  logic        load_done = 1'b0;
  logic        comp_done = 1'b0;
  logic        wb_done = 1'b0;
  logic        load_req, comp_req, wb_req;
  logic        busy, done, cfg_err;
  logic [4:0]  load_row, load_col;
  logic [16:0] wb_addr_base;
  logic [10:0] tiles_done;

  int total = 0;
  int bad = 0;
  int ld_log[$];
  int wb_log[$];
  bit overlap_seen = 1'b0;

  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_row_tiles (cfg_row_tiles),
    .cfg_col_tiles (cfg_col_tiles),
    .load_req      (load_req),
    .load_row      (load_row),
    .load_col      (load_col),
    .load_done     (load_done),
    .comp_req      (comp_req),
    .comp_done     (comp_done),
    .wb_req        (wb_req),
    .wb_addr_base  (wb_addr_base),
    .wb_done       (wb_done),
    .tiles_done    (tiles_done),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always @(negedge clk)
    if (comp_req && wb_req) overlap_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input bit l, input bit c, input bit w);
    load_done = l;
    comp_done = c;
    wb_done   = w;
    tick();
    load_done = 1'b0;
    comp_done = 1'b0;
    wb_done   = 1'b0;
  endtask

  task automatic do_start(input int r, input int c);
    cfg_row_tiles = 6'(r);
    cfg_col_tiles = 6'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hi(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((sel == 0 && load_req) || (sel == 1 && comp_req)
          || (sel == 2 && wb_req)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drive_run(input int nt, input int dly, output bit ok);
    bit w;
    ok = 1'b1;
    ld_log.delete();
    wb_log.delete();
    wait_hi(0, w);
    if (!w) begin
      ok = 1'b0;
      return;
    end
    ld_log.push_back(int'(load_row) * 32 + int'(load_col));
    idle_n(dly);
    pulse(1, 0, 0);
    for (int t = 0; t < nt; t++) begin
      wait_hi(1, w);
      if (!w) begin
        ok = 1'b0;
        return;
      end
      idle_n(dly);
      pulse(0, 1, 0);
      wait_hi(2, w);
      if (!w) begin
        ok = 1'b0;
        return;
      end
      wb_log.push_back(int'(wb_addr_base));
      if (load_req)
        ld_log.push_back(int'(load_row) * 32 + int'(load_col));
      idle_n(dly);
      pulse(load_req, 0, 1);
    end
  endtask

  task automatic test_reset();
    idle_n(2);
    total++;
    if ({load_req, comp_req, wb_req, busy, done, cfg_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {load_req, comp_req, wb_req, busy, done, cfg_err});
    end
    total++;
    if ({load_row, load_col, wb_addr_base, tiles_done} !== 38'b0) begin
      bad++;
      $display("FAIL reset_data got=%0h exp=0",
               {load_row, load_col, wb_addr_base, tiles_done});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    pulse(1, 1, 1);
    total++;
    if ({busy, load_req, comp_req, wb_req, tiles_done} !== 15'b0) begin
      bad++;
      $display("FAIL idle_done_ignored got=%0h exp=0",
               {busy, load_req, comp_req, wb_req, tiles_done});
    end
  endtask

  task automatic test_single();
    do_start(1, 1);
    total++;
    if ({busy, load_req, done} !== 3'b110) begin
      bad++;
      $display("FAIL single_start got=%b exp=110", {busy, load_req, done});
    end
    do_start(2, 2);
    pulse(0, 1, 0);
    total++;
    if ({busy, load_req, comp_req, cfg_err} !== 4'b1100) begin
      bad++;
      $display("FAIL start_while_busy got=%b exp=1100",
               {busy, load_req, comp_req, cfg_err});
    end
    idle_n(3);
    pulse(1, 0, 0);
    total++;
    if ({load_req, comp_req} !== 2'b01) begin
      bad++;
      $display("FAIL single_comp got=%b exp=01", {load_req, comp_req});
    end
    idle_n(3);
    pulse(0, 1, 0);
    total++;
    if ({load_req, comp_req, wb_req} !== 3'b001 || wb_addr_base !== 17'd0) begin
      bad++;
      $display("FAIL single_wb got=%b addr=%0d exp=001 addr=0",
               {load_req, comp_req, wb_req}, wb_addr_base);
    end
    idle_n(3);
    pulse(0, 0, 1);
    idle_n(2);
    total++;
    if ({done, busy, wb_req} !== 3'b100 || tiles_done !== 11'd1) begin
      bad++;
      $display("FAIL single_done got=%b tiles=%0d exp=100 tiles=1",
               {done, busy, wb_req}, tiles_done);
    end
  endtask

  task automatic test_grid_2x3();
    int exp_ld[6] = '{0, 1, 2, 32, 33, 34};
    int exp_wb[6] = '{0, 128, 256, 4096, 4224, 4352};
    bit ok;
    overlap_seen = 1'b0;
    do_start(2, 3);
    drive_run(6, 3, ok);
    total++;
    if (!ok || ld_log.size() != 6 || wb_log.size() != 6) begin
      bad++;
      $display("FAIL grid_run ok=%0d loads=%0d wbs=%0d exp=1/6/6",
               ok, ld_log.size(), wb_log.size());
    end
    for (int i = 0; i < 6; i++) begin
      if (i < ld_log.size()) begin
        total++;
        if (ld_log[i] != exp_ld[i]) begin
          bad++;
          $display("FAIL grid_load%0d got=%0d exp=%0d", i, ld_log[i], exp_ld[i]);
        end
      end
      if (i < wb_log.size()) begin
        total++;
        if (wb_log[i] != exp_wb[i]) begin
          bad++;
          $display("FAIL grid_addr%0d got=%0d exp=%0d", i, wb_log[i], exp_wb[i]);
        end
      end
    end
    total++;
    if (tiles_done !== 11'd6 || done !== 1'b1 || overlap_seen) begin
      bad++;
      $display("FAIL grid_end tiles=%0d done=%b ovl=%0d exp=6 1 0",
               tiles_done, done, overlap_seen);
    end
  endtask

  task automatic test_ovl(input int dl, input int dw);
    int m;
    m = (dl > dw) ? dl : dw;
    overlap_seen = 1'b0;
    do_start(1, 2);
    idle_n(1);
    pulse(1, 0, 0);
    idle_n(1);
    pulse(0, 1, 0);
    total++;
    if ({load_req, wb_req, comp_req} !== 3'b110 || load_col !== 5'd1
        || wb_addr_base !== 17'd0) begin
      bad++;
      $display("FAIL ovl_enter_%0d_%0d got=%b col=%0d addr=%0d exp=110 1 0",
               dl, dw, {load_req, wb_req, comp_req}, load_col, wb_addr_base);
    end
    for (int k = 1; k <= m + 1; k++) begin
      load_done = (k == dl);
      wb_done   = (k == dw);
      tick();
      load_done = 1'b0;
      wb_done   = 1'b0;
      total++;
      if ({comp_req, load_req, wb_req} !== {k >= m, k < dl, k < dw}) begin
        bad++;
        $display("FAIL ovl_%0d_%0d_step%0d got=%b exp=%b", dl, dw, k,
                 {comp_req, load_req, wb_req}, {k >= m, k < dl, k < dw});
      end
    end
    idle_n(1);
    pulse(0, 1, 0);
    total++;
    if ({wb_req, load_req} !== 2'b10 || wb_addr_base !== 17'd128) begin
      bad++;
      $display("FAIL ovl_last_wb_%0d_%0d got=%b addr=%0d exp=10 addr=128",
               dl, dw, {wb_req, load_req}, wb_addr_base);
    end
    pulse(0, 0, 1);
    total++;
    if (done !== 1'b1 || tiles_done !== 11'd2 || overlap_seen) begin
      bad++;
      $display("FAIL ovl_done_%0d_%0d done=%b tiles=%0d ovl=%0d exp=1 2 0",
               dl, dw, done, tiles_done, overlap_seen);
    end
  endtask

  task automatic test_cfg_err();
    int rv[3] = '{0, 33, 4};
    int cv[3] = '{4, 4, 0};
    for (int i = 0; i < 3; i++) begin
      do_start(rv[i], cv[i]);
      total++;
      if ({cfg_err, busy, load_req, done} !== 4'b1001) begin
        bad++;
        $display("FAIL cfg_err_%0dx%0d got=%b exp=1001",
                 rv[i], cv[i], {cfg_err, busy, load_req, done});
      end
      tick();
      total++;
      if ({cfg_err, busy} !== 2'b00) begin
        bad++;
        $display("FAIL cfg_err_pulse_%0dx%0d got=%b exp=00",
                 rv[i], cv[i], {cfg_err, busy});
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(2, 2);
    idle_n(1);
    pulse(1, 0, 0);
    idle_n(1);
    pulse(0, 1, 0);
    total++;
    if ({load_req, wb_req} !== 2'b11) begin
      bad++;
      $display("FAIL mid_ovl got=%b exp=11", {load_req, wb_req});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({load_req, comp_req, wb_req, busy, done, cfg_err, load_row,
         load_col, wb_addr_base, tiles_done} !== 44'b0) begin
      bad++;
      $display("FAIL async_rst got=%0h exp=0",
               {load_req, comp_req, wb_req, busy, done, cfg_err, load_row,
                load_col, wb_addr_base, tiles_done});
    end
    @(negedge clk);
    rst = 1'b0;
    overlap_seen = 1'b0;
    do_start(32, 32);
    total++;
    if ({busy, load_req} !== 2'b11 || {load_row, load_col} !== 10'b0) begin
      bad++;
      $display("FAIL first_edge_start got=%b idx=%0h exp=11 0",
               {busy, load_req}, {load_row, load_col});
    end
    drive_run(1024, 1, ok);
    total++;
    if (!ok || tiles_done !== 11'd1024 || done !== 1'b1) begin
      bad++;
      $display("FAIL full_run ok=%0d tiles=%0d done=%b exp=1 1024 1",
               ok, tiles_done, done);
    end
    total++;
    if (wb_log.size() != 1024 || wb_log[wb_log.size()-1] != 130944) begin
      bad++;
      $display("FAIL full_last_addr n=%0d got=%0d exp=1024 130944",
               wb_log.size(),
               (wb_log.size() > 0) ? wb_log[wb_log.size()-1] : -1);
    end
    total++;
    if (ld_log.size() != 1024 || ld_log[ld_log.size()-1] != 1023
        || overlap_seen) begin
      bad++;
      $display("FAIL full_loads n=%0d last=%0d ovl=%0d exp=1024 1023 0",
               ld_log.size(),
               (ld_log.size() > 0) ? ld_log[ld_log.size()-1] : -1,
               overlap_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_grid_2x3();
    test_ovl(2, 5);
    test_ovl(5, 2);
    test_ovl(3, 3);
    test_cfg_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
